// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef logic [MEM_ADDR_W-1:0] MemAddr;
    typedef logic [MEM_DATA_W-1:0] MemValue;

    // UART data register is a normal backend access; status is answered locally
    localparam MemAddr UartAddr     = 16'hBF00;
    localparam MemAddr UartStatAddr = 16'hBF01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCAL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Status word layout: bit1 = receive data available, bit0 = transmitter idle
    function automatic MemValue uart_status_word(input logic rx_avail, input logic tx_idle);
        return {{(MEM_DATA_W-2){1'b0}}, rx_avail, tx_idle};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long a backend transaction may stay outstanding.
// expired is high in the TIMEOUT-th enabled cycle after a clear; never when TIMEOUT = 0.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST_I  = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LAST  = LAST_I[CW-1:0];
    localparam logic          ACTIVE = (TIMEOUT != 0);

    logic [CW-1:0] count_r;

    // Count enabled cycles; clear has priority so every WAIT entry starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = ACTIVE && en && (count_r == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM1/UART port between instruction fetch and data memory.
// MEM beats IF; UART status reads are answered locally; hung backend accesses time out.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = UartAddr,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = UartStatAddr,
    parameter int                TIMEOUT        = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              be_need_to_work,
    output logic              be_rd,
    output logic              be_wr,
    output logic [ADDR_W-1:0] be_addr,
    output logic [DATA_W-1:0] be_wdata,
    output logic [31:0]       be_act,
    input  logic              be_done,
    input  logic [DATA_W-1:0] be_result,
    input  logic              uart_rx_avail,
    input  logic              uart_tx_idle,
    output logic              timeout_err
);

    arb_state_e        state_r;
    owner_e            owner_r;
    logic              we_r;

    logic              grant_valid_s;
    owner_e            grant_owner_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic              grant_we_s;
    logic [DATA_W-1:0] grant_wdata_s;
    logic              stat_hit_s;

    logic              finish_s;
    logic [DATA_W-1:0] finish_data_s;
    logic              finish_to_s;
    logic              expired_s;

    // Timeout counter: held clear while idle so it starts at zero on WAIT entry
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_r == ST_IDLE),
        .en      (state_r == ST_WAIT),
        .expired (expired_s)
    );

    // Fixed-priority grant selection; IF requests are always reads
    always_comb begin
        grant_valid_s = 1'b0;
        grant_owner_s = OWN_IF;
        grant_addr_s  = '0;
        grant_we_s    = 1'b0;
        grant_wdata_s = '0;
        if (mem_req) begin
            grant_valid_s = 1'b1;
            grant_owner_s = OWN_MEM;
            grant_addr_s  = mem_addr;
            grant_we_s    = mem_we;
            grant_wdata_s = mem_wdata;
        end else if (if_req) begin
            grant_valid_s = 1'b1;
            grant_owner_s = OWN_IF;
            grant_addr_s  = if_addr;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // The UART data register always belongs to the backend, even if misconfigured onto status
    assign stat_hit_s = (grant_addr_s == UART_STAT_ADDR) && (UART_STAT_ADDR != UART_DATA_ADDR);

    // Completion decision for LOCAL and WAIT; a real completion beats a same-cycle timeout
    always_comb begin
        finish_s      = 1'b0;
        finish_data_s = '0;
        finish_to_s   = 1'b0;
        case (state_r)
            ST_LOCAL: begin
                finish_s = 1'b1;
                if (we_r) begin
                    finish_data_s = '0;
                end else begin
                    finish_data_s = DATA_W'(uart_status_word(uart_rx_avail, uart_tx_idle));
                end
            end
            ST_WAIT: begin
                if (be_done) begin
                    finish_s      = 1'b1;
                    finish_data_s = be_result;
                end else if (expired_s) begin
                    finish_s      = 1'b1;
                    finish_data_s = '1;
                    finish_to_s   = 1'b1;
                end else begin
                    finish_s      = 1'b0;
                end
            end
            default: begin
                finish_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM with all pipeline- and backend-facing outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            owner_r         <= OWN_IF;
            we_r            <= 1'b0;
            be_act          <= 32'd0;
            be_need_to_work <= 1'b0;
            be_rd           <= 1'b0;
            be_wr           <= 1'b0;
            be_addr         <= '0;
            be_wdata        <= '0;
            if_ready        <= 1'b0;
            mem_ready       <= 1'b0;
            if_rdata        <= '0;
            mem_rdata       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        // be_addr/be_wdata double as the latched request fields
                        owner_r  <= grant_owner_s;
                        we_r     <= grant_we_s;
                        be_addr  <= grant_addr_s;
                        be_wdata <= grant_wdata_s;
                        if (stat_hit_s) begin
                            state_r <= ST_LOCAL;
                        end else begin
                            // Fresh tag lets the backend ignore a stale completion after a timeout
                            be_act          <= be_act + 32'd1;
                            be_need_to_work <= 1'b1;
                            be_rd           <= ~grant_we_s;
                            be_wr           <= grant_we_s;
                            state_r         <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCAL, ST_WAIT: begin
                    if (finish_s) begin
                        be_need_to_work <= 1'b0;
                        be_rd           <= 1'b0;
                        be_wr           <= 1'b0;
                        timeout_err     <= finish_to_s;
                        if (owner_r == OWN_MEM) begin
                            mem_ready <= 1'b1;
                            mem_rdata <= finish_data_s;
                        end else begin
                            if_ready  <= 1'b1;
                            if_rdata  <= finish_data_s;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected backend
// requests and completions; monitors pop and compare when the DUT presents them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        be_need_to_work;
    logic        be_rd;
    logic        be_wr;
    logic [15:0] be_addr;
    logic [15:0] be_wdata;
    logic [31:0] be_act;
    logic        be_done;
    logic [15:0] be_result;
    logic        uart_rx_avail;
    logic        uart_tx_idle;
    logic        timeout_err;

    mem_port_arbiter #(
        .TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_ready        (if_ready),
        .if_rdata        (if_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .be_need_to_work (be_need_to_work),
        .be_rd           (be_rd),
        .be_wr           (be_wr),
        .be_addr         (be_addr),
        .be_wdata        (be_wdata),
        .be_act          (be_act),
        .be_done         (be_done),
        .be_result       (be_result),
        .uart_rx_avail   (uart_rx_avail),
        .uart_tx_idle    (uart_tx_idle),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_mem;
        logic [15:0] data;
        int          at;
        bit          to;
    } rdy_t;

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wdata;
        logic [31:0] tag;
    } be_t;

    rdy_t        rdy_q[$];
    be_t         be_q[$];
    logic [31:0] exp_tag = 32'd0;

    int          be_delay    = 3;
    logic [15:0] resp_data   = 16'h0000;
    bit          resp_by_tag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    task automatic push_be(input logic [15:0] addr, input bit wr, input logic [15:0] wdata);
        exp_tag = exp_tag + 32'd1;
        be_q.push_back('{addr: addr, wr: wr, wdata: wdata, tag: exp_tag});
    endtask

    task automatic push_rdy(input bit is_mem, input logic [15:0] data, input int at, input bit to);
        rdy_q.push_back('{is_mem: is_mem, data: data, at: at, to: to});
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor
    initial begin
        rdy_t e;
        forever begin
            @(negedge clk);
            if (if_ready || mem_ready) begin
                if (rdy_q.size() == 0) begin
                    fail("unexpected_ready", $sformatf("if_ready=%0b mem_ready=%0b with nothing pending", if_ready, mem_ready));
                end else begin
                    e = rdy_q.pop_front();
                    chk("ready_owner_mem", {31'd0, mem_ready}, {31'd0, e.is_mem});
                    chk("ready_owner_if", {31'd0, if_ready}, {31'd0, ~e.is_mem});
                    chk("rdata", {16'd0, (e.is_mem ? mem_rdata : if_rdata)}, {16'd0, e.data});
                    chk("ready_cycle", cyc, e.at);
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
                end
            end else if (timeout_err) begin
                fail("stray_timeout", "timeout_err high without a ready pulse");
            end
        end
    end

    // Backend request monitor
    initial begin
        be_t  b;
        logic prev_need = 1'b0;
        forever begin
            @(negedge clk);
            if (be_need_to_work && !prev_need) begin
                if (be_q.size() == 0) begin
                    fail("unexpected_backend", $sformatf("addr=%h act=%h", be_addr, be_act));
                end else begin
                    b = be_q.pop_front();
                    chk("be_addr", {16'd0, be_addr}, {16'd0, b.addr});
                    chk("be_wr", {31'd0, be_wr}, {31'd0, b.wr});
                    chk("be_rd", {31'd0, be_rd}, {31'd0, ~b.wr});
                    if (b.wr) chk("be_wdata", {16'd0, be_wdata}, {16'd0, b.wdata});
                    chk("be_act", be_act, b.tag);
                end
            end
            prev_need = be_need_to_work;
        end
    end

    // Backend responder: be_done pulses in the be_delay-th WAIT cycle (0 = never)
    initial begin
        int cnt = 0;
        be_done   = 1'b0;
        be_result = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            be_done = 1'b0;
            if (be_need_to_work) begin
                cnt++;
                if (be_delay > 0 && cnt == be_delay) begin
                    be_done   = 1'b1;
                    be_result = resp_by_tag ? (16'hC000 | {8'h00, be_act[7:0]}) : resp_data;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic txn(input bit is_mem, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        int  k = 0;
        logic seen = 1'b0;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            seen = is_mem ? mem_ready : if_ready;
        end
        if (!seen) fail("ready_wait", $sformatf("no ready for addr %h within 60 cycles", addr));
        sync();
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 16'h0000;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        uart_rx_avail = 1'b0; uart_tx_idle = 1'b0;
        repeat (3) sync();

        chk("rst_be_act", be_act, 32'd0);
        chk("rst_be_need", {31'd0, be_need_to_work}, 32'd0);
        chk("rst_be_strobes", {30'd0, be_rd, be_wr}, 32'd0);
        chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 32'd0);
        chk("rst_be_addr_wdata", {be_addr, be_wdata}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // IF read of 4000, backend answers 1234 in the 3rd WAIT cycle
        sync();
        be_delay = 3; resp_data = 16'h1234;
        push_be(16'h4000, 1'b0, 16'h0000);
        push_rdy(1'b0, 16'h1234, cyc + 4, 1'b0);
        txn(1'b0, 1'b0, 16'h4000, 16'h0000);

        // Simultaneous requests: MEM write first, then IF read
        sync();
        resp_data = 16'h0BAD;
        push_be(16'h8000, 1'b1, 16'hBEEF);
        push_be(16'h4002, 1'b0, 16'h0000);
        push_rdy(1'b1, 16'h0BAD, cyc + 4, 1'b0);
        push_rdy(1'b0, 16'h0BAD, cyc + 9, 1'b0);
        fork
            txn(1'b1, 1'b1, 16'h8000, 16'hBEEF);
            txn(1'b0, 1'b0, 16'h4002, 16'h0000);
        join

        // Local UART status accesses
        uart_rx_avail = 1'b1; uart_tx_idle = 1'b0;
        sync();
        push_rdy(1'b1, 16'h0002, cyc + 2, 1'b0);
        txn(1'b1, 1'b0, 16'hBF01, 16'h0000);
        uart_rx_avail = 1'b0; uart_tx_idle = 1'b1;
        sync();
        push_rdy(1'b0, 16'h0001, cyc + 2, 1'b0);
        txn(1'b0, 1'b0, 16'hBF01, 16'h0000);
        uart_rx_avail = 1'b1; uart_tx_idle = 1'b1;
        sync();
        push_rdy(1'b1, 16'h0000, cyc + 2, 1'b0);
        txn(1'b1, 1'b1, 16'hBF01, 16'h5555);

        // Timeout after 8 WAIT cycles, then a normal MEM read with the next tag
        be_delay = 0;
        sync();
        push_be(16'h4010, 1'b0, 16'h0000);
        push_rdy(1'b0, 16'hFFFF, cyc + 9, 1'b1);
        txn(1'b0, 1'b0, 16'h4010, 16'h0000);
        be_delay = 2; resp_data = 16'h5A5A;
        sync();
        push_be(16'h8010, 1'b0, 16'h0000);
        push_rdy(1'b1, 16'h5A5A, cyc + 3, 1'b0);
        txn(1'b1, 1'b0, 16'h8010, 16'h0000);

        // Reset in the middle of WAIT aborts without a ready pulse
        be_delay = 0;
        sync();
        push_be(16'h4020, 1'b0, 16'h0000);
        if_req = 1'b1; if_addr = 16'h4020;
        repeat (3) sync();
        chk("wait_be_need", {31'd0, be_need_to_work}, 32'd1);
        rst = 1'b1; if_req = 1'b0;
        sync();
        chk("midrst_be_need", {31'd0, be_need_to_work}, 32'd0);
        chk("midrst_be_act", be_act, 32'd0);
        chk("midrst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
        rst = 1'b0;
        exp_tag = 32'd0;
        repeat (12) sync();
        chk("midrst_be_q_drained", be_q.size(), 32'd0);

        // Continuous IF fetches, backend answers in the first WAIT cycle
        be_delay = 1; resp_by_tag = 1'b1;
        sync();
        n = cyc;
        for (int i = 1; i <= 4; i++) begin
            push_be(16'h4100, 1'b0, 16'h0000);
            push_rdy(1'b0, 16'hC000 | 16'(i), n + 2 + 3 * (i - 1), 1'b0);
        end
        if_req = 1'b1; if_addr = 16'h4100;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!if_ready && k < 40);
            if (!if_ready) fail("fetch_wait", $sformatf("fetch %0d never completed", i + 1));
        end
        sync();
        if_req = 1'b0;

        repeat (6) sync();
        chk("rdy_q_empty", rdy_q.size(), 32'd0);
        chk("be_q_empty", be_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
